// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator with IF/ID pipeline register.
// Chooses the next fetch PC from the ID redirect, the BTB prediction or the
// sequential step, and captures the fetched PC and its prediction for ID.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             btb_en_i,
  input  logic             btb_jump_i,
  input  logic [31:0]      btb_pc_pre_i,
  input  logic             imem_ready_i,
  output logic [31:0]      pc_o,
  output logic             imem_req_o,
  output logic             id_valid_o,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_pc_4_o,
  output logic             id_pred_taken_o,
  output logic [31:0]      id_pred_pc_o,
  output logic             flush_d_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state;
  logic        taken;
  logic [31:0] seq_pc;
  logic [31:0] npc;

  // Low address bits of the targets are dropped: fetch is always word aligned.
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc_i[1:0], btb_pc_pre_i[1:0]};

  // Next-PC selection for the advance case: BTB-predicted target or sequential.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    taken  = 1'b0;
    seq_pc = pc_o + STEP;
    npc    = seq_pc;
    if (btb_en_i && btb_jump_i) begin
      taken = 1'b1;
      npc   = {btb_pc_pre_i[31:2], 2'b00};
    end
  end

  // Fetch FSM, PC register, IF/ID register, flush pulse and redirect counter.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= BOOT;
      pc_o            <= RESET_PC;
      imem_req_o      <= 1'b0;
      id_valid_o      <= 1'b0;
      id_pc_o         <= '0;
      id_pc_4_o       <= '0;
      id_pred_taken_o <= 1'b0;
      id_pred_pc_o    <= '0;
      flush_d_o       <= 1'b0;
      redirect_cnt_o  <= '0;
    end else begin
      flush_d_o <= 1'b0;
      case (state)
        BOOT: begin
          state      <= FETCH;
          imem_req_o <= 1'b1;
        end
        default: begin
          if (redirect_i) begin
            // Mispredict flush wins over everything, including a stall.
            pc_o       <= {redirect_pc_i[31:2], 2'b00};
            id_valid_o <= 1'b0;
            flush_d_o  <= 1'b1;
            if (redirect_cnt_o != '1) redirect_cnt_o <= redirect_cnt_o + 1'b1;
            state      <= FETCH;
          end else if (stall_i) begin
            // Hold PC, IF/ID contents and state.
          end else if (!imem_ready_i) begin
            id_valid_o <= 1'b0;
            state      <= WAIT;
          end else begin
            pc_o            <= npc;
            id_valid_o      <= 1'b1;
            id_pc_o         <= pc_o;
            id_pc_4_o       <= seq_pc;
            id_pred_taken_o <= taken;
            id_pred_pc_o    <= npc;
            state           <= FETCH;
          end
        end
      endcase
    end
  end

endmodule
